// File: rtl/dcache_ctrl.sv
// Direct-mapped, one-word-line, write-through / no-write-allocate data cache controller.
// Read hits answer combinationally in IDLE; misses and all writes stall the pipeline until memory acks.
module dcache_ctrl #(
  parameter int INDEX_BITS = 5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  input  logic        inv_i,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 30 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU, RESP} state_t;

  state_t                  state;
  logic [LINES-1:0]        valid;
  logic [TAG_W-1:0]        tag_mem  [LINES];
  logic [31:0]             data_mem [LINES];
  logic [31:0]             resp_q;

  logic [INDEX_BITS-1:0]   idx, fill_idx;
  logic [TAG_W-1:0]        tag, fill_tag;
  logic                    hit, lookup_hit, ack, fill_en, wr_hit_en;
  logic                    unused_addr_lsb;

  assign idx      = cpu_addr_i[INDEX_BITS+1:2];
  assign tag      = cpu_addr_i[31:INDEX_BITS+2];
  assign fill_idx = mem_addr_o[INDEX_BITS+1:2];
  assign fill_tag = mem_addr_o[31:INDEX_BITS+2];
  assign unused_addr_lsb = ^cpu_addr_i[1:0];

  assign hit        = valid[idx] && (tag_mem[idx] == tag);
  // An invalidate in the same cycle wins over the lookup, so the fill lands after the clear.
  assign lookup_hit = hit && !inv_i;
  assign ack        = mem_req_o && mem_ack_i;
  assign fill_en    = !rst_i && (state == RD_MISS) && ack;
  assign wr_hit_en  = !rst_i && (state == IDLE) && cpu_req_i && cpu_we_i && lookup_hit;

  always_comb begin
    cpu_stall_o = 1'b0;
    cpu_rdata_o = '0;
    case (state)
      IDLE: begin
        cpu_stall_o = cpu_req_i && (cpu_we_i || !lookup_hit);
        if (cpu_req_i && !cpu_we_i && lookup_hit) cpu_rdata_o = data_mem[idx];
      end
      RD_MISS, WR_THRU: cpu_stall_o = 1'b1;
      RESP:             cpu_rdata_o = resp_q;
      default: ;
    endcase
    if (rst_i && !cpu_req_i) cpu_stall_o = 1'b0;
  end

  // Line storage carries no reset; the valid bits alone decide what is cached.
  always_ff @(posedge clk_i) begin
    if (fill_en) begin
      data_mem[fill_idx] <= mem_rdata_i;
      tag_mem[fill_idx]  <= fill_tag;
    end else if (wr_hit_en) begin
      data_mem[idx] <= cpu_wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      valid       <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      resp_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (inv_i) valid <= '0;
          if (cpu_req_i) begin
            if (cpu_we_i) begin
              state       <= WR_THRU;
              mem_req_o   <= 1'b1;
              mem_we_o    <= 1'b1;
              mem_addr_o  <= {cpu_addr_i[31:2], 2'b00};
              mem_wdata_o <= cpu_wdata_i;
            end else if (!lookup_hit) begin
              state      <= RD_MISS;
              mem_req_o  <= 1'b1;
              mem_we_o   <= 1'b0;
              mem_addr_o <= {cpu_addr_i[31:2], 2'b00};
            end
          end
        end
        RD_MISS: if (ack) begin
          valid[fill_idx] <= 1'b1;
          resp_q          <= mem_rdata_i;
          mem_req_o       <= 1'b0;
          state           <= RESP;
        end
        WR_THRU: if (ack) begin
          resp_q    <= '0;
          mem_req_o <= 1'b0;
          state     <= RESP;
        end
        // The stalled request is consumed here; the pipeline advances past it.
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios plus random traffic against a
// line-level cache/memory reference model; a behavioural memory answers bus requests.
module tb_dcache_ctrl;
  localparam int IB    = 5;
  localparam int LINES = 1 << IB;

  logic        clk_i = 1'b0, rst_i, cpu_req_i, cpu_we_i, inv_i, mem_ack_i;
  logic [31:0] cpu_addr_i, cpu_wdata_i, cpu_rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        cpu_stall_o, mem_req_o, mem_we_o;

  always #5 clk_i = ~clk_i;

  dcache_ctrl #(.INDEX_BITS(IB)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i),
    .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i), .inv_i(inv_i),
    .cpu_rdata_o(cpu_rdata_o), .cpu_stall_o(cpu_stall_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
  );

  int n_cmp = 0, n_bad = 0;
  int lat = 3;
  bit hold_ack = 0, late_ack = 0;
  int mem_txn_cnt = 0, unstable_cnt = 0;
  logic [31:0] last_addr = '0, last_wdata = '0;
  logic        last_we = 1'b0;
  logic [31:0] ram     [logic [29:0]];
  logic [31:0] mdl_mem [logic [29:0]];
  bit          mdl_valid [LINES];
  logic [31:0] mdl_tag   [LINES];
  logic [31:0] mdl_data  [LINES];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  // Memory: acks the lat-th cycle of a request, records each transaction, flags unstable bus fields.
  initial begin : responder
    int age;
    age = 0; mem_ack_i = 1'b0; mem_rdata_i = '0;
    forever begin
      @(posedge clk_i); #1;
      mem_ack_i = 1'b0; mem_rdata_i = '0;
      if (late_ack) begin
        mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD0_BAD0; late_ack = 0;
      end else if (mem_req_o === 1'b1) begin
        age++;
        if (age == 1) begin
          mem_txn_cnt++; last_addr = mem_addr_o; last_we = mem_we_o; last_wdata = mem_wdata_o;
        end else if (mem_addr_o !== last_addr || mem_we_o !== last_we ||
                     (last_we && mem_wdata_o !== last_wdata)) unstable_cnt++;
        if (!hold_ack && age >= lat) begin
          mem_ack_i = 1'b1;
          if (mem_we_o) ram[mem_addr_o[31:2]] = mem_wdata_o;
          else mem_rdata_i = ram.exists(mem_addr_o[31:2]) ? ram[mem_addr_o[31:2]] : init_val(mem_addr_o);
        end
      end else age = 0;
    end
  end

  // Reference: what a write-through, no-write-allocate direct-mapped cache should do per access.
  function automatic void mdl_step(input logic we, input logic inv, input logic [31:0] a,
                                   input logic [31:0] wd, output int st, output logic [31:0] rd,
                                   output int ntx);
    int i;
    logic [31:0] t;
    bit h;
    i = int'((a >> 2) % LINES);
    t = a >> (IB + 2);
    if (inv) foreach (mdl_valid[k]) mdl_valid[k] = 0;
    h = mdl_valid[i] && (mdl_tag[i] == t);
    if (we) begin
      st = 1 + lat; rd = '0; ntx = 1;
      mdl_mem[a[31:2]] = wd;
      if (h) mdl_data[i] = wd;
    end else if (h) begin
      st = 0; rd = mdl_data[i]; ntx = 0;
    end else begin
      st = 1 + lat; ntx = 1;
      rd = mdl_mem.exists(a[31:2]) ? mdl_mem[a[31:2]] : init_val({a[31:2], 2'b00});
      mdl_valid[i] = 1; mdl_tag[i] = t; mdl_data[i] = rd;
    end
  endfunction

  // Drives one CPU access from posedge+1 and returns stall cycles, answered data and bus transactions.
  task automatic do_access(input logic we, input logic inv, input logic [31:0] a, input logic [31:0] wd,
                           output int st, output logic [31:0] rd, output int ntx);
    int t0;
    bit done;
    t0 = mem_txn_cnt; st = 0; rd = '0; done = 0;
    cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = a; cpu_wdata_i = wd; inv_i = inv;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk_i);
      if (cpu_stall_o === 1'b0) begin rd = cpu_rdata_o; done = 1; end
      else st++;
      @(posedge clk_i); #1;
      inv_i = 1'b0;
    end
    if (!done) st = -1;
    cpu_req_i = 1'b0; cpu_we_i = 1'b0;
    ntx = mem_txn_cnt - t0;
  endtask

  task automatic run_op(input logic we, input logic inv, input logic [31:0] a, input logic [31:0] wd,
                        output int st, output logic [31:0] rd, output int ntx,
                        output int est, output logic [31:0] erd, output int entx);
    do_access(we, inv, a, wd, st, rd, ntx);
    mdl_step(we, inv, a, wd, est, erd, entx);
  endtask

  task automatic test_reset();
    rst_i = 1'b1; cpu_req_i = 1'b0; cpu_we_i = 1'b0; inv_i = 1'b0;
    cpu_addr_i = '0; cpu_wdata_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    n_cmp++; if (cpu_stall_o !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", cpu_stall_o); end
    n_cmp++; if (mem_req_o !== 1'b0) begin n_bad++; $display("FAIL reset_mem_req: got %b want 0", mem_req_o); end
    n_cmp++; if ({mem_we_o, mem_addr_o, mem_wdata_o} !== 65'd0) begin n_bad++;
      $display("FAIL reset_bus: got we=%b addr=%h wd=%h want all 0", mem_we_o, mem_addr_o, mem_wdata_o); end
    n_cmp++; if (cpu_rdata_o !== 32'd0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", cpu_rdata_o); end
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    foreach (mdl_valid[k]) mdl_valid[k] = 0;
  endtask

  task automatic test_cold_read();
    int st, ntx, est, entx;
    logic [31:0] rd, erd;
    lat = 3;
    ram[30'h10] = 32'hDEAD_BEEF; mdl_mem[30'h10] = 32'hDEAD_BEEF;
    for (int k = 0; k < 2; k++) begin
      run_op(1'b0, 1'b0, 32'h40, '0, st, rd, ntx, est, erd, entx);
      n_cmp++; if (st !== (k == 0 ? 4 : 0)) begin n_bad++; $display("FAIL cold_stall[%0d]: got %0d want %0d", k, st, k == 0 ? 4 : 0); end
      n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL cold_rdata[%0d]: got %h want deadbeef", k, rd); end
      n_cmp++; if (ntx !== (k == 0 ? 1 : 0)) begin n_bad++; $display("FAIL cold_txn[%0d]: got %0d want %0d", k, ntx, k == 0 ? 1 : 0); end
    end
    n_cmp++; if (last_addr !== 32'h40 || last_we !== 1'b0) begin n_bad++;
      $display("FAIL cold_bus: got addr=%h we=%b want 00000040 0", last_addr, last_we); end
    @(negedge clk_i);
    n_cmp++; if (cpu_rdata_o !== 32'd0 || cpu_stall_o !== 1'b0) begin n_bad++;
      $display("FAIL idle_outputs: got rdata=%h stall=%b want 0 0", cpu_rdata_o, cpu_stall_o); end
    @(posedge clk_i); #1;
  endtask

  task automatic test_write_hit();
    int st, ntx, est, entx;
    logic [31:0] rd, erd;
    lat = 2;
    run_op(1'b1, 1'b0, 32'h40, 32'h1234_5678, st, rd, ntx, est, erd, entx);
    n_cmp++; if (st !== 3 || ntx !== 1) begin n_bad++; $display("FAIL wr_stall_txn: got %0d/%0d want 3/1", st, ntx); end
    n_cmp++; if (last_we !== 1'b1 || last_addr !== 32'h40 || last_wdata !== 32'h1234_5678) begin n_bad++;
      $display("FAIL wr_bus: got we=%b addr=%h wd=%h want 1 00000040 12345678", last_we, last_addr, last_wdata); end
    n_cmp++; if (rd !== erd) begin n_bad++; $display("FAIL wr_rdata: got %h want %h", rd, erd); end
    run_op(1'b0, 1'b0, 32'h40, '0, st, rd, ntx, est, erd, entx);
    n_cmp++; if (st !== 0 || ntx !== 0) begin n_bad++; $display("FAIL wr_reread_hit: got stall %0d txn %0d want 0 0", st, ntx); end
    n_cmp++; if (rd !== 32'h1234_5678) begin n_bad++; $display("FAIL wr_reread_data: got %h want 12345678", rd); end
  endtask

  task automatic test_conflict();
    int st, ntx, est, entx;
    logic [31:0] rd, erd;
    logic [31:0] seq_a [4];
    int seq_st [4];
    lat = 1;
    seq_a = '{32'hC0, 32'h40, 32'h40, 32'hC0};
    seq_st = '{2, 2, 0, 2};
    for (int k = 0; k < 4; k++) begin
      run_op(1'b0, 1'b0, seq_a[k], '0, st, rd, ntx, est, erd, entx);
      n_cmp++; if (st !== seq_st[k] || st !== est) begin n_bad++;
        $display("FAIL conflict_stall[%0d]: got %0d want %0d", k, st, seq_st[k]); end
      n_cmp++; if (rd !== erd || ntx !== entx) begin n_bad++;
        $display("FAIL conflict_data[%0d]: got %h/%0d want %h/%0d", k, rd, ntx, erd, entx); end
    end
  endtask

  task automatic test_write_miss();
    int st, ntx, est, entx;
    logic [31:0] rd, erd, wd;
    lat = 2; wd = $urandom;
    run_op(1'b1, 1'b0, 32'h80, wd, st, rd, ntx, est, erd, entx);
    n_cmp++; if (st !== 3 || ntx !== 1 || last_wdata !== wd) begin n_bad++;
      $display("FAIL wmiss_write: got stall %0d txn %0d wd %h want 3 1 %h", st, ntx, last_wdata, wd); end
    run_op(1'b0, 1'b0, 32'h80, '0, st, rd, ntx, est, erd, entx);
    n_cmp++; if (st !== 3 || ntx !== 1) begin n_bad++; $display("FAIL wmiss_no_alloc: got stall %0d txn %0d want 3 1", st, ntx); end
    n_cmp++; if (rd !== wd || rd !== erd) begin n_bad++; $display("FAIL wmiss_read_data: got %h want %h", rd, wd); end
  endtask

  task automatic test_invalidate();
    int st, ntx, est, entx;
    logic [31:0] rd, erd;
    int exp_st [4];
    lat = 2;
    exp_st = '{3, 0, 3, 3};
    for (int k = 0; k < 4; k++) begin
      if (k == 2) begin
        inv_i = 1'b1; @(posedge clk_i); #1; inv_i = 1'b0;
        foreach (mdl_valid[j]) mdl_valid[j] = 0;
      end
      // k == 3: lookup coincides with an invalidate and must miss
      run_op(1'b0, k == 3, 32'h100, '0, st, rd, ntx, est, erd, entx);
      n_cmp++; if (st !== exp_st[k]) begin n_bad++; $display("FAIL inv_stall[%0d]: got %0d want %0d", k, st, exp_st[k]); end
      n_cmp++; if (rd !== erd) begin n_bad++; $display("FAIL inv_rdata[%0d]: got %h want %h", k, rd, erd); end
    end
  endtask

  task automatic test_reset_mid();
    int st, ntx, est, entx;
    logic [31:0] rd, erd;
    lat = 3; hold_ack = 1;
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h104;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    n_cmp++; if (cpu_stall_o !== 1'b1 || mem_req_o !== 1'b1) begin n_bad++;
      $display("FAIL rmid_inflight: got stall=%b req=%b want 1 1", cpu_stall_o, mem_req_o); end
    @(posedge clk_i); #1;
    rst_i = 1'b1; cpu_req_i = 1'b0;
    @(negedge clk_i);
    n_cmp++; if (cpu_stall_o !== 1'b0) begin n_bad++; $display("FAIL rmid_stall_in_reset: got %b want 0", cpu_stall_o); end
    @(posedge clk_i); #1;
    rst_i = 1'b0; hold_ack = 0; late_ack = 1;
    @(negedge clk_i);
    n_cmp++; if (mem_req_o !== 1'b0) begin n_bad++; $display("FAIL rmid_req_drop: got %b want 0", mem_req_o); end
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    n_cmp++; if (mem_req_o !== 1'b0 || cpu_stall_o !== 1'b0 || cpu_rdata_o !== 32'd0) begin n_bad++;
      $display("FAIL rmid_late_ack: got req=%b stall=%b rdata=%h want 0 0 0", mem_req_o, cpu_stall_o, cpu_rdata_o); end
    @(posedge clk_i); #1;
    foreach (mdl_valid[k]) mdl_valid[k] = 0;
    // 0x100 was cached before the reset; 0x104 was the abandoned fill
    run_op(1'b0, 1'b0, 32'h100, '0, st, rd, ntx, est, erd, entx);
    n_cmp++; if (st !== 4 || rd !== erd) begin n_bad++; $display("FAIL rmid_reread_100: got %0d %h want 4 %h", st, rd, erd); end
    run_op(1'b0, 1'b0, 32'h104, '0, st, rd, ntx, est, erd, entx);
    n_cmp++; if (st !== 4 || rd !== erd) begin n_bad++; $display("FAIL rmid_reread_104: got %0d %h want 4 %h", st, rd, erd); end
  endtask

  task automatic test_random();
    int st, ntx, est, entx;
    logic [31:0] rd, erd, a, wd;
    logic we, inv;
    for (int k = 0; k < 80; k++) begin
      lat = int'($urandom_range(1, 4));
      a   = ($urandom_range(0, 3) << (IB + 2)) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      we  = ($urandom_range(0, 2) == 0);
      inv = ($urandom_range(0, 11) == 0);
      wd  = $urandom;
      run_op(we, inv, a, wd, st, rd, ntx, est, erd, entx);
      n_cmp++; if (st !== est || rd !== erd || ntx !== entx) begin n_bad++;
        $display("FAIL rand[%0d] we=%b inv=%b a=%h: got st=%0d rd=%h tx=%0d want st=%0d rd=%h tx=%0d",
                 k, we, inv, a, st, rd, ntx, est, erd, entx); end
    end
    n_cmp++; if (unstable_cnt !== 0) begin n_bad++; $display("FAIL bus_stable: got %0d changes want 0", unstable_cnt); end
  endtask

  initial begin
    test_reset();
    test_cold_read();
    test_write_hit();
    test_conflict();
    test_write_miss();
    test_invalidate();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
